vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//   Shares the single-port 2 KiB video RAM between the video fetch path (the VBS
//   pixel generator) and the Z8 CPU bus. Video reads have absolute priority and a
//   fixed latency. The CPU gets read/write access with a req/ack handshake in the
//   cycles video leaves free. Sits between the video generator, the CPU memory
//   decoder, and the RAM macro.
// PARAMETERS
//   ADDR_W  11  VRAM address width (2048 bytes)
//   DATA_W   8  VRAM data width
// PORTS
//   clk        in   1       system clock (8 MHz pixel clock)
//   reset      in   1       synchronous, active-high reset
//   vid_req    in   1       single-cycle video read request
//   vid_addr   in   ADDR_W  video read address, valid with vid_req
//   vid_valid  out  1       pulse: vid_data holds the result of the request 2 cycles earlier
//   vid_data   out  DATA_W  video read data (registered)
//   cpu_req    in   1       CPU request; held high until cpu_ack
//   cpu_we     in   1       1 = write, 0 = read; stable while cpu_req is high
//   cpu_addr   in   ADDR_W  CPU address; stable while cpu_req is high
//   cpu_wdata  in   DATA_W  CPU write data; stable while cpu_req is high
//   cpu_ack    out  1       single-cycle completion pulse
//   cpu_rdata  out  DATA_W  read data, valid with cpu_ack on reads
//   ram_en     out  1       RAM access strobe (combinational from grant)
//   ram_we     out  1       RAM write enable (qualified by ram_en)
//   ram_addr   out  ADDR_W  RAM address
//   ram_wdata  out  DATA_W  RAM write data
//   ram_rdata  in   DATA_W  RAM registered read data; valid 1 cycle after ram_en
// BEHAVIOUR
//   - Reset values: vid_valid=0, vid_data=0, cpu_ack=0, cpu_rdata=0,
//     ram_en=0, ram_we=0, state=IDLE.
//   - Grant (cycle N): vid_req always wins. ram_en=1, ram_we=0, ram_addr=vid_addr.
//     ram_rdata is captured into vid_data at the N+1 edge, so vid_valid=1 in cycle N+2.
//   - FSM states: IDLE, CPU_RD_WAIT, CPU_ACK.
//     IDLE: on cpu_req && !vid_req, issue the CPU access in the same cycle.
//       Write: ram_we=1, then go to CPU_ACK; cpu_ack=1 in N+1.
//       Read: go to CPU_RD_WAIT; capture ram_rdata into cpu_rdata; cpu_ack=1 in N+2.
//     CPU_RD_WAIT: the RAM port is free, so a vid_req is still granted here.
//     CPU_ACK: cpu_ack pulses for 1 cycle; cpu_req is ignored in this cycle
//       (turnaround); then return to IDLE.
//   - Collision (vid_req && cpu_req in IDLE): the CPU is deferred to the next free
//     cycle. Video is never stalled. If vid_req stays high every cycle, the CPU may
//     wait unboundedly; this is legal.
//   - At most one RAM access per cycle. ram_rdata in N+1 belongs to the single
//     requester that was granted in N.
//   - Reset mid-operation: any pending CPU access is dropped without an ack, and an
//     in-flight video read produces no vid_valid. The requester must re-issue.
// CONFIGURATION
//   VRAM_POSTED_WRITE_EN defined: adds a 1-entry write buffer.
//     - A CPU write is acked in N+1 whenever the buffer is empty, even if vid_req
//       is high.
//     - The buffer drains to RAM in the first cycle with no vid_req and no CPU read
//       issue; buffer drain has priority over a new CPU read.
//     - A write arriving while the buffer is full waits until it drains.
//     - A CPU read hitting the buffered address returns buffer data with normal
//       N+2 ack timing.
//     - A video read hitting the buffered address returns buffer data with the same
//       fixed latency.
//     - Reset discards the buffered write.
//   VRAM_POSTED_WRITE_EN undefined: writes arbitrate exactly like reads, as above.
// STRUCTURE
//   - Shared include vram_defs.vh: VRAM_ADDR_W, VRAM_DATA_W, FSM state encodings.
//   - Sub-module vram_posted_wbuf: holds valid/addr/data, provides the address-match
//     forward and the drain request. Instantiated only under VRAM_POSTED_WRITE_EN.
// TESTING
//   1. CPU write 0x5A @0x123, no video -> ram_we=1 in N, cpu_ack in N+1.
//      Then a read @0x123 -> cpu_ack in N+2 with cpu_rdata=0x5A.
//   2. vid_req @0x000 and CPU read @0x010 in the same cycle -> ram_addr=0x000 in N,
//      vid_valid in N+2; CPU read issued in N+1, cpu_ack in N+3.
//   3. vid_req every 8 cycles plus back-to-back CPU reads for 200 cycles ->
//      every vid_valid arrives exactly 2 cycles after its vid_req, and no CPU ack
//      is lost or duplicated.
//   4. reset asserted in CPU_RD_WAIT -> no cpu_ack; all outputs 0 next cycle;
//      a new request afterwards completes normally.
//   5. (POSTED) vid_req held high for 4 cycles; CPU write 0xA5 @0x040 -> cpu_ack in
//      N+1; ram_we fires in the first cycle without vid_req; a CPU read @0x040
//      before the drain returns 0xA5.
//   6. (no POSTED) same stimulus -> cpu_ack only in the cycle after vid_req drops.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared widths and arbiter FSM encoding for the VRAM arbiter slice.
package vram_arbiter_pkg;
    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_CPU_RD_WAIT = 2'd1,
        ST_CPU_ACK     = 2'd2
    } arbStateT;
endpackage

// File: rtl/vram_posted_wbuf.sv
// One-entry posted write buffer for the VRAM arbiter (used only with VRAM_POSTED_WRITE_EN).
// Holds one CPU write, forwards it to matching reads and drains it when the RAM port is free.
module vram_posted_wbuf
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0] loadData,
    input  logic              portFree,
    input  logic [ADDR_W-1:0] vidAddr,
    input  logic [ADDR_W-1:0] cpuAddr,
    output logic              full,
    output logic              drainGo,
    output logic              vidHit,
    output logic              cpuHit,
    output logic [ADDR_W-1:0] bufAddr,
    output logic [DATA_W-1:0] bufData
);
    logic valid;

    assign full    = valid;
    assign drainGo = valid && portFree;
    assign vidHit  = valid && (vidAddr == bufAddr);
    assign cpuHit  = valid && (cpuAddr == bufAddr);

    // load is only ever asserted while the buffer is empty, so it never races a drain
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            bufAddr <= '0;
            bufData <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            bufAddr <= loadAddr;
            bufData <= loadData;
        end else if (drainGo) begin
            valid   <= 1'b0;
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: video reads win every cycle with a fixed 2-cycle latency; the CPU gets
// the leftover cycles via req/ack. Define VRAM_POSTED_WRITE_EN for a 1-entry posted write buffer.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    // state          | meaning
    // ST_IDLE        | accepting a CPU request; issued when the RAM port is free
    // ST_CPU_RD_WAIT | CPU read in flight; read data captured at the end of this cycle
    // ST_CPU_ACK     | cpu_ack pulse; cpu_req ignored (turnaround)
    arbStateT state, stateNext;

    logic              cpuIdleReq;
    logic              cpuWrIssue;
    logic              cpuRdIssue;
    logic              vidPend;
    logic [DATA_W-1:0] rdCapture;
    logic [DATA_W-1:0] vidCapture;

    assign cpuIdleReq = (state == ST_IDLE) && cpu_req;

`ifdef VRAM_POSTED_WRITE_EN
    logic              bufFull, drainGo, bufVidHit, bufCpuHit, rdViaRam;
    logic [ADDR_W-1:0] bufAddr;
    logic [DATA_W-1:0] bufData;
    logic              rdHit, vidHit;
    logic [DATA_W-1:0] rdHitData, vidHitData;

    vram_posted_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (cpuWrIssue),
        .loadAddr (cpu_addr),
        .loadData (cpu_wdata),
        .portFree (!vid_req),
        .vidAddr  (vid_addr),
        .cpuAddr  (cpu_addr),
        .full     (bufFull),
        .drainGo  (drainGo),
        .vidHit   (bufVidHit),
        .cpuHit   (bufCpuHit),
        .bufAddr  (bufAddr),
        .bufData  (bufData)
    );

    // A read that hits the buffer needs no RAM slot, so it may issue alongside video
    assign cpuWrIssue = cpuIdleReq && cpu_we && !bufFull;
    assign rdViaRam   = cpuIdleReq && !cpu_we && !bufCpuHit && !vid_req && !drainGo;
    assign cpuRdIssue = (cpuIdleReq && !cpu_we && bufCpuHit) || rdViaRam;

    assign ram_en    = vid_req || drainGo || rdViaRam;
    assign ram_we    = drainGo;
    assign ram_addr  = vid_req ? vid_addr : (drainGo ? bufAddr : cpu_addr);
    assign ram_wdata = bufData;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdHit      <= 1'b0;
            rdHitData  <= '0;
            vidHit     <= 1'b0;
            vidHitData <= '0;
        end else begin
            if (cpuRdIssue) begin
                rdHit     <= bufCpuHit;
                rdHitData <= bufData;
            end
            vidHit     <= vid_req && bufVidHit;
            vidHitData <= bufData;
        end
    end

    assign rdCapture  = rdHit  ? rdHitData  : ram_rdata;
    assign vidCapture = vidHit ? vidHitData : ram_rdata;
`else
    assign cpuWrIssue = cpuIdleReq && cpu_we && !vid_req;
    assign cpuRdIssue = cpuIdleReq && !cpu_we && !vid_req;

    assign ram_en    = vid_req || cpuWrIssue || cpuRdIssue;
    assign ram_we    = cpuWrIssue;
    assign ram_addr  = vid_req ? vid_addr : cpu_addr;
    assign ram_wdata = cpu_wdata;

    assign rdCapture  = ram_rdata;
    assign vidCapture = ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (cpuWrIssue)      stateNext = ST_CPU_ACK;
                else if (cpuRdIssue) stateNext = ST_CPU_RD_WAIT;
            end
            ST_CPU_RD_WAIT: stateNext = ST_CPU_ACK;
            ST_CPU_ACK:     stateNext = ST_IDLE;
            default:        stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_ack = (state == ST_CPU_ACK);
    end

    // ram_rdata in cycle N+1 belongs to whoever was granted in N
    always_ff @(posedge clk) begin
        if (reset) begin
            vidPend   <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
        end else begin
            vidPend   <= vid_req;
            vid_valid <= vidPend;
            if (vidPend)                  vid_data  <= vidCapture;
            if (state == ST_CPU_RD_WAIT)  cpu_rdata <= rdCapture;
        end
    end
endmodule
